fetch_unit: RTL and testbench

- Instruction-fetch front end, directly upstream of the fetch/decode pipeline register.
- Owns the architectural PC and selects next-PC from redirect, interrupt, halt, prediction or sequential increment.
- Issues byte-wide instruction memory requests and presents one fetch slot per cycle: the instr, valid, halt, interrupt, int_code, pc, pc_override and target fields the fetch/decode register latches.
- A small FSM handles halt and interrupt entry.

---
 rtl/fetch_unit.sv | 161 ++++++++++++++++
 tb/tb_fetch_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end.
// Owns the architectural PC, issues byte-wide imem requests and presents one
// fetch slot per cycle to the fetch/decode register. A small FSM handles
// halt and interrupt entry.
//
// Optional feature macro: BRANCH_PREDICT_EN
//   defined   : predict_taken/predict_target steer RUN slots and next-PC
//   undefined : predictor inputs ignored, RUN slots never override the PC
//
// state   | meaning
// --------+-----------------------------------------------
// S_RUN   | normal fetch, slot valid when imem_ready
// S_INT   | interrupt slot pending, no memory access needed
// S_HALTED| halt accepted, no fetch until resume/int_req
module fetch_unit #(
  parameter int                   PC_SIZE         = 16,
  parameter logic [PC_SIZE-1:0]   RESET_PC        = '0,
  parameter logic [7:0]           HALT_OPCODE     = 8'hFF,
  parameter logic [PC_SIZE-1:0]   INT_VECTOR_BASE = PC_SIZE'(16'h0010),
  parameter int                   INT_STRIDE_LOG2 = 2
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               retain,
  input  logic               redirect,
  input  logic [PC_SIZE-1:0] redirect_target,
  input  logic               predict_taken,
  input  logic [PC_SIZE-1:0] predict_target,
  output logic [PC_SIZE-1:0] imem_addr,
  input  logic [7:0]         imem_data,
  input  logic               imem_ready,
  input  logic               int_req,
  input  logic [3:0]         int_code_in,
  output logic               int_ack,
  input  logic               resume,
  output logic               valid,
  output logic               halt,
  output logic               interrupt,
  output logic [3:0]         int_code,
  output logic [PC_SIZE-1:0] pc,
  output logic               pc_override,
  output logic [PC_SIZE-1:0] target,
  output logic [7:0]         instr
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_INT    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t             state;
  logic [PC_SIZE-1:0] pc_reg;
  logic [PC_SIZE-1:0] pc_inc;
  logic [PC_SIZE-1:0] int_target;
  logic               pred_taken_eff;
  logic [PC_SIZE-1:0] pred_target_eff;
  logic               advance;

`ifdef BRANCH_PREDICT_EN
  assign pred_taken_eff  = predict_taken;
  assign pred_target_eff = predict_target;
`else
  // Predictor inputs are deliberately unused in this build.
  logic unused_predict;
  assign unused_predict  = ^{predict_taken, predict_target};
  assign pred_taken_eff  = 1'b0;
  assign pred_target_eff = '0;
`endif

  assign pc_inc     = pc_reg + PC_SIZE'(1);
  assign int_target = INT_VECTOR_BASE + (PC_SIZE'(int_code_in) << INT_STRIDE_LOG2);
  assign imem_addr  = pc_reg;
  assign pc         = pc_reg;

  // Slot contents; flags are held at zero while reset is asserted so the
  // downstream register never latches a slot during reset.
  always_comb begin
    valid       = 1'b0;
    halt        = 1'b0;
    interrupt   = 1'b0;
    int_code    = 4'd0;
    pc_override = 1'b0;
    target      = '0;
    instr       = 8'h00;
    case (state)
      S_RUN: begin
        valid       = imem_ready;
        instr       = imem_data;
        halt        = (imem_data == HALT_OPCODE);
        pc_override = pred_taken_eff & ~(imem_data == HALT_OPCODE);
        target      = pred_target_eff;
      end
      S_INT: begin
        valid       = 1'b1;
        interrupt   = 1'b1;
        int_code    = int_code_in;
        pc_override = 1'b1;
        target      = int_target;
      end
      default: ;
    endcase
    if (redirect) valid = 1'b0;
    if (!n_rst) begin
      valid       = 1'b0;
      halt        = 1'b0;
      interrupt   = 1'b0;
      int_code    = 4'd0;
      pc_override = 1'b0;
      target      = '0;
      instr       = 8'h00;
    end
  end

  // Handshake with the fetch/decode register; valid already excludes redirect.
  always_comb begin
    advance = valid & ~retain;
    int_ack = (state == S_INT) & advance;
  end

  // PC and FSM update: redirect wins, otherwise move only on slot acceptance
  // (or on halt exit, which needs no slot).
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pc_reg <= RESET_PC;
      state  <= S_RUN;
    end else if (redirect) begin
      pc_reg <= redirect_target;
      state  <= S_RUN;
    end else begin
      case (state)
        S_RUN: begin
          if (advance) begin
            if (halt) begin
              pc_reg <= pc_inc;
              state  <= S_HALTED;
            end else if (pc_override) begin
              pc_reg <= pred_target_eff;
            end else begin
              pc_reg <= pc_inc;
            end
          end
          // An accepted halt wins; the wake-up happens from S_HALTED instead.
          if (int_req && !(advance && halt)) state <= S_INT;
        end
        S_INT: begin
          if (advance) begin
            pc_reg <= int_target;
            state  <= S_RUN;
          end
        end
        S_HALTED: begin
          if (int_req)     state <= S_INT;
          else if (resume) state <= S_RUN;
        end
        default: state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit (RESET_PC = 0x0040).
module tb_fetch_unit;

`ifdef BRANCH_PREDICT_EN
  localparam bit PRED = 1'b1;
`else
  localparam bit PRED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        n_rst;
  logic        retain, redirect, predict_taken, imem_ready, int_req, resume;
  logic [15:0] redirect_target, predict_target;
  logic [7:0]  imem_data;
  logic [3:0]  int_code_in;
  logic [15:0] imem_addr, pc, target;
  logic        int_ack, valid, halt, interrupt, pc_override;
  logic [3:0]  int_code;
  logic [7:0]  instr;

  int total = 0;
  int bad   = 0;

  fetch_unit #(
    .PC_SIZE(16), .RESET_PC(16'h0040), .HALT_OPCODE(8'hFF),
    .INT_VECTOR_BASE(16'h0010), .INT_STRIDE_LOG2(2)
  ) dut (
    .clk(clk), .n_rst(n_rst), .retain(retain), .redirect(redirect),
    .redirect_target(redirect_target), .predict_taken(predict_taken),
    .predict_target(predict_target), .imem_addr(imem_addr), .imem_data(imem_data),
    .imem_ready(imem_ready), .int_req(int_req), .int_code_in(int_code_in),
    .int_ack(int_ack), .resume(resume), .valid(valid), .halt(halt),
    .interrupt(interrupt), .int_code(int_code), .pc(pc), .pc_override(pc_override),
    .target(target), .instr(instr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ret, rdr;
    logic [15:0] rtgt;
    logic        pt;
    logic [15:0] ptgt;
    logic        rdy;
    logic [7:0]  data;
    logic        ireq;
    logic [3:0]  icode;
    logic        res;
    logic [64:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Packed view: {imem_addr, valid, halt, interrupt, int_code, pc, pc_override, target, instr, int_ack}
  function automatic logic [64:0] pk(logic v, logic h, logic i, logic [3:0] c, logic [15:0] p,
                                     logic o, logic [15:0] t, logic [7:0] ins, logic a);
    return {p, v, h, i, c, p, o, t, ins, a};
  endfunction

  function automatic logic [64:0] outs();
    return {imem_addr, valid, halt, interrupt, int_code, pc, pc_override, target, instr, int_ack};
  endfunction

  function automatic void add(logic ret, logic rdr, logic [15:0] rtgt, logic pt, logic [15:0] ptgt,
                              logic rdy, logic [7:0] data, logic ireq, logic [3:0] icode, logic res,
                              logic [64:0] exp);
    vec_t v;
    v.ret = ret; v.rdr = rdr; v.rtgt = rtgt; v.pt = pt; v.ptgt = ptgt; v.rdy = rdy;
    v.data = data; v.ireq = ireq; v.icode = icode; v.res = res; v.exp = exp;
    vecs.push_back(v);
  endfunction

  task automatic drive(vec_t v);
    retain = v.ret; redirect = v.rdr; redirect_target = v.rtgt;
    predict_taken = v.pt; predict_target = v.ptgt; imem_ready = v.rdy;
    imem_data = v.data; int_req = v.ireq; int_code_in = v.icode; resume = v.res;
  endtask

  task automatic idle();
    retain = 0; redirect = 0; redirect_target = 0; predict_taken = 0; predict_target = 0;
    imem_ready = 0; imem_data = 0; int_req = 0; int_code_in = 0; resume = 0;
  endtask

  task automatic check(string name, logic [64:0] act, logic [64:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] p2;
    logic [15:0] t1;
    p2 = PRED ? 16'h0100 : 16'h0042;
    t1 = PRED ? 16'h0100 : 16'h0000;

    //  ret rdr rtgt      pt ptgt      rdy data  ireq ic  res  expected
    add(0, 0, 16'h0000, 0, 16'h0000, 1, 8'h12, 0, 0, 0, pk(1,0,0,0,16'h0040,0,16'h0000,8'h12,0));
    add(0, 0, 16'h0000, 1, 16'h0100, 1, 8'h34, 0, 0, 0, pk(1,0,0,0,16'h0041,PRED,t1,8'h34,0));
    add(0, 1, 16'h0050, 0, 16'h0000, 1, 8'h00, 0, 0, 0, pk(0,0,0,0,p2,0,16'h0000,8'h00,0));
    add(0, 0, 16'h0000, 0, 16'h0000, 1, 8'hFF, 0, 0, 0, pk(1,1,0,0,16'h0050,0,16'h0000,8'hFF,0));
    add(0, 0, 16'h0000, 0, 16'h0000, 1, 8'h12, 0, 0, 0, pk(0,0,0,0,16'h0051,0,16'h0000,8'h00,0));
    add(0, 0, 16'h0000, 0, 16'h0000, 1, 8'h12, 0, 0, 1, pk(0,0,0,0,16'h0051,0,16'h0000,8'h00,0));
    add(0, 0, 16'h0000, 0, 16'h0000, 0, 8'h20, 0, 0, 0, pk(0,0,0,0,16'h0051,0,16'h0000,8'h20,0));
    add(0, 0, 16'h0000, 0, 16'h0000, 1, 8'h21, 0, 0, 0, pk(1,0,0,0,16'h0051,0,16'h0000,8'h21,0));
    add(0, 1, 16'h0060, 0, 16'h0000, 1, 8'h22, 0, 0, 0, pk(0,0,0,0,16'h0052,0,16'h0000,8'h22,0));
    add(1, 0, 16'h0000, 0, 16'h0000, 1, 8'h33, 1, 3, 0, pk(1,0,0,0,16'h0060,0,16'h0000,8'h33,0));
    add(1, 0, 16'h0000, 0, 16'h0000, 1, 8'h33, 1, 3, 0, pk(1,0,1,3,16'h0060,1,16'h001C,8'h00,0));
    add(1, 0, 16'h0000, 0, 16'h0000, 1, 8'h33, 1, 3, 0, pk(1,0,1,3,16'h0060,1,16'h001C,8'h00,0));
    add(0, 0, 16'h0000, 0, 16'h0000, 1, 8'h33, 1, 3, 0, pk(1,0,1,3,16'h0060,1,16'h001C,8'h00,1));
    add(0, 0, 16'h0000, 0, 16'h0000, 1, 8'h44, 0, 0, 0, pk(1,0,0,0,16'h001C,0,16'h0000,8'h44,0));
    add(0, 0, 16'h0000, 0, 16'h0000, 0, 8'h45, 1, 5, 0, pk(0,0,0,0,16'h001D,0,16'h0000,8'h45,0));
    add(0, 1, 16'h0080, 0, 16'h0000, 1, 8'h00, 1, 5, 0, pk(0,0,1,5,16'h001D,1,16'h0024,8'h00,0));
    add(0, 0, 16'h0000, 0, 16'h0000, 1, 8'h55, 1, 5, 0, pk(1,0,0,0,16'h0080,0,16'h0000,8'h55,0));
    add(0, 0, 16'h0000, 0, 16'h0000, 1, 8'h56, 0, 5, 0, pk(1,0,1,5,16'h0081,1,16'h0024,8'h00,1));
    add(0, 0, 16'h0000, 0, 16'h0000, 1, 8'hFF, 1, 1, 0, pk(1,1,0,0,16'h0024,0,16'h0000,8'hFF,0));
    add(0, 0, 16'h0000, 0, 16'h0000, 1, 8'hFF, 1, 1, 1, pk(0,0,0,0,16'h0025,0,16'h0000,8'h00,0));
    add(0, 0, 16'h0000, 0, 16'h0000, 1, 8'h00, 1, 1, 0, pk(1,0,1,1,16'h0025,1,16'h0014,8'h00,1));
    add(0, 0, 16'h0000, 0, 16'h0000, 1, 8'h66, 0, 0, 0, pk(1,0,0,0,16'h0014,0,16'h0000,8'h66,0));

    idle();
    n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    imem_ready = 1; imem_data = 8'h12;
    #1;
    check("reset_state", outs(), pk(0,0,0,0,16'h0040,0,16'h0000,8'h00,0));
    #1;
    n_rst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(negedge clk);
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
      step();
    end

    // Redirect out of HALTED
    idle(); imem_ready = 1; imem_data = 8'hFF;
    @(negedge clk);
    check("halt_at_15", outs(), pk(1,1,0,0,16'h0015,0,16'h0000,8'hFF,0));
    step();
    idle(); redirect = 1; redirect_target = 16'h0200; imem_ready = 1;
    @(negedge clk);
    check("halted_redirect", outs(), pk(0,0,0,0,16'h0016,0,16'h0000,8'h00,0));
    step();
    idle(); imem_ready = 1; imem_data = 8'h01;
    @(negedge clk);
    check("after_halt_redirect", outs(), pk(1,0,0,0,16'h0200,0,16'h0000,8'h01,0));
    step();

    // PC wrap
    idle(); redirect = 1; redirect_target = 16'hFFFF;
    step();
    idle(); imem_ready = 1; imem_data = 8'h02;
    @(negedge clk);
    check("pc_ffff", outs(), pk(1,0,0,0,16'hFFFF,0,16'h0000,8'h02,0));
    step();
    idle();
    @(negedge clk);
    check("pc_wrap", outs(), pk(0,0,0,0,16'h0000,0,16'h0000,8'h00,0));
    step();

    // Reset asserted while an interrupt slot is stalled
    idle(); retain = 1; imem_ready = 1; int_req = 1; int_code_in = 4'd2;
    step();
    @(negedge clk);
    check("int_stalled", outs(), pk(1,0,1,2,16'h0000,1,16'h0018,8'h00,0));
    #2;
    n_rst = 1'b0;
    #1;
    check("reset_mid_stall", outs(), pk(0,0,0,0,16'h0040,0,16'h0000,8'h00,0));
    @(posedge clk);
    #1;
    idle(); n_rst = 1'b1; imem_ready = 1; imem_data = 8'h77;
    @(negedge clk);
    check("restart_fetch", outs(), pk(1,0,0,0,16'h0040,0,16'h0000,8'h77,0));
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
